// File: rtl/mem_responder_pkg.sv
// Shared state encoding, request types and defaults for the memory responder
// and its RAM.
package mem_pkg;

    localparam int DEF_DEPTH       = 256;
    localparam int DEF_WAIT_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        REQ_RD = 1'b0,
        REQ_WR = 1'b1
    } req_t;

    function automatic logic addr_in_range(input logic [31:0] a, input int depth);
        return a < 32'(depth);
    endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Synchronous single-port 16-bit RAM with registered read (read-before-write).
// Contents are not reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int IW    = 8
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [IW-1:0] addr,
    input  logic [15:0]   din,
    output logic [15:0]   dout
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: one request at a time, ack after WAIT_CYCLES+1.
// Optional write protection of the low region with MEM_RESPONDER_WRPROT_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int AW          = 16,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
`ifdef MEM_RESPONDER_WRPROT_EN
    ,
    parameter int PROT_LIMIT  = 32
`endif
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          rd_req,
    input  logic          wr_req,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata,
    output logic          ack,
    output logic          busy,
    output logic          err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(WAIT_CYCLES + 2);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    req_t          req_q, req_d;
    logic          bad_q, bad_d;
    logic [15:0]   rdata_q, rdata_d;

    logic          req_bad;
    logic [IW-1:0] ram_addr;
    logic          ram_we;
    logic [15:0]   ram_dout;
    logic [15:0]   resp_data;

    // Request classification happens once, at acceptance; later input changes
    // cannot turn a good request bad or vice versa.
    always_comb begin
        req_bad = (rd_req && wr_req) || !addr_in_range(32'(addr), DEPTH);
`ifdef MEM_RESPONDER_WRPROT_EN
        if (wr_req && (32'(addr) < 32'(PROT_LIMIT))) begin
            req_bad = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        req_d   = req_q;
        bad_d   = bad_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (rd_req || wr_req) begin
                    addr_d  = addr[IW-1:0];
                    wdata_d = wdata;
                    req_d   = (wr_req && !rd_req) ? REQ_WR : REQ_RD;
                    bad_d   = req_bad;
                    cnt_d   = CW'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rdata_d = resp_data;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            req_q   <= REQ_RD;
            bad_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            req_q   <= req_d;
            bad_q   <= bad_d;
            rdata_q <= rdata_d;
        end
    end

    // The RAM read is launched at acceptance (live address) so that the
    // registered read data is already present in RESP even with zero wait states.
    assign ram_addr = (state_q == IDLE) ? addr[IW-1:0] : addr_q;
    assign ram_we   = (state_q == RESP) && (req_q == REQ_WR) && !bad_q;

    mem_array #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_ram (
        .CLK  (CLK),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (wdata_q),
        .dout (ram_dout)
    );

    always_comb begin
        resp_data = rdata_q;
        if (bad_q) begin
            resp_data = '0;
        end else if (req_q == REQ_RD) begin
            resp_data = ram_dout;
        end
    end

    assign ack   = (state_q == RESP);
    assign busy  = (state_q != IDLE);
    assign err   = ack && bad_q;
    assign rdata = ack ? resp_data : rdata_q;

    a_ack_pulse: assert property (@(posedge CLK) disable iff (!reset) ack |=> !ack);
    a_err_ack:   assert property (@(posedge CLK) disable iff (!reset) err |-> ack);

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the CPU's load/store/fetch port. Accepts one read or write request at a time from the initiator (CPU FSM), inserts a programmable number of wait states, then completes the access with a one-cycle ack. It backs a word-addressed 16-bit RAM, flags bad requests with an error, and replaces the zero-latency memory model so the FSM can be exercised against real handshakes.

Parameters:
DEPTH, 256, number of 16-bit words; valid addresses are 0..DEPTH-1.
AW, 16, address width, matching the CPU address bus.
WAIT_CYCLES, 2, wait states between acceptance and ack (0 allowed).

Ports:
CLK  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (asserted at 0).
rd_req  input  1  read request, held by the initiator until ack.
wr_req  input  1  write request, held by the initiator until ack.
addr  input  AW  word address, stable while a request is held.
wdata  input  16  write data, stable while wr_req is held.
rdata  output  16  read data, valid in the ack cycle and held until the next ack.
ack  output  1  one-cycle completion pulse.
busy  output  1  high from acceptance up to and including the ack cycle.
err  output  1  valid with ack; request was rejected.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, rdata=0, ack=0, busy=0, err=0, wait counter=0. RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if rd_req|wr_req, latch addr, wdata and the request type, set busy=1, load counter=WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, else to RESP.
  - WAIT: decrement the counter. When it reaches 1, go to RESP.
  - RESP: perform the access on the latched values, drive ack=1 for exactly this cycle, update rdata/err, then return to IDLE. busy falls the cycle after ack.
- Latency: ack is asserted WAIT_CYCLES+1 cycles after the request is sampled in IDLE.
- Initiator rule: requests stay asserted until ack. The responder uses only the latched values; changes after acceptance are ignored.
- A request still high in the IDLE cycle after ack is a new request. Back-to-back accesses cost WAIT_CYCLES+2 cycles each.
- Errors (err=1 with ack, no RAM write, rdata forced to 0):
  - rd_req and wr_req both high when sampled;
  - addr >= DEPTH.
- On a successful write: RAM[addr]<=wdata in RESP, and rdata keeps its previous value.
- On a successful read: rdata<=RAM[addr] in RESP (registered); err=0.
- Read-after-write to the same address in consecutive transactions returns the new data.
- Reset during WAIT/RESP aborts the transaction: no ack, and no write unless the RAM write edge already occurred.
- Address indexing uses addr[$clog2(DEPTH)-1:0] only after the range check.

Optional Feature:
Macro MEM_RESPONDER_WRPROT_EN.
- Defined: adds parameter PROT_LIMIT (default 32). Writes to addr < PROT_LIMIT are rejected with err=1 and do not modify the RAM; reads there are unaffected. This protects the program image.
- Undefined: every in-range address is writable, and PROT_LIMIT does not exist.

Decomposition:
- Shared package mem_pkg: state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2), request-type constants (REQ_RD, REQ_WR), default DEPTH/WAIT_CYCLES.
- One sub-module, mem_array: synchronous single-port RAM (CLK, we, addr, din, dout) with registered read, instantiated once. The FSM, latching and error logic stay in mem_responder.

Test Plan:
- WAIT_CYCLES=2: write addr=5 wdata=16'hBEEF -> ack 3 cycles after the request, err=0. Then read addr=5 -> rdata=16'hBEEF with ack, busy high for 3 cycles.
- WAIT_CYCLES=0: read addr=5 -> ack the cycle after the request. Hold rd_req high -> second ack 2 cycles later, same data.
- Read addr=DEPTH (256) -> ack with err=1, rdata=0. Write addr=300 -> err=1, and a subsequent read of addr=300&255 returns its prior value.
- rd_req=wr_req=1 at addr=7 -> err=1 and RAM[7] unchanged; change addr/wdata mid-WAIT -> the latched original address is used.
- Assert reset=0 during WAIT -> ack/busy/err drop immediately, no ack follows, and the FSM accepts a new request after reset=1.
- With MEM_RESPONDER_WRPROT_EN: write addr=3 -> err=1 and RAM[3] unchanged; write addr=40 -> err=0. Without the macro, write addr=3 succeeds.
